multicycle_control: RTL and testbench

Sequencing control for the multi-cycle TSC core. It steps each instruction through IF, ID, EX, MEM and WB states, waits on a ready handshake from the memory, and retires instructions. It also counts retired instructions and stops the core on HLT or on a memory timeout. It sits next to the combinational decoder and ALU control, which keep producing datapath selects (pc_src, alu_src_*, reg_dst, reg_write_src, alu_op). This block supplies every write-enable and memory-request strobe with correct cycle timing.

---
 rtl/multicycle_control_if.sv | 19 +
 rtl/multicycle_control.sv | 186 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Memory request bus between the multi-cycle controller and instruction/data memory.
// A request strobe stays high and steady until mem_ready is seen high in the same cycle; that edge completes the transfer.
interface multicycle_control_if;
  logic i_mem_read;
  logic d_mem_read;
  logic d_mem_write;
  logic i_or_d;
  logic mem_ready;

  modport master (
    output i_mem_read, d_mem_read, d_mem_write, i_or_d,
    input  mem_ready
  );

  modport slave (
    input  i_mem_read, d_mem_read, d_mem_write, i_or_d,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_control.sv
// Sequencing FSM for the multi-cycle TSC core: IF/ID/EX/MEM/WB with memory handshake,
// retired-instruction counter, HLT stop and optional memory timeout.
module multicycle_control #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 0,
  parameter int FAST_PATH   = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [3:0]           opcode,
  input  logic [5:0]           func_code,
  input  logic [2:0]           inst_type,
  input  logic                 bcond,
  multicycle_control_if.master mem,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic                 reg_write,
  output logic                 output_write,
  output logic                 halted,
  output logic                 mem_error,
  output logic [CNT_W-1:0]     num_inst,
  output logic [2:0]           stage
);

  localparam logic [2:0] IT_RTYPE  = 3'd0;
  localparam logic [2:0] IT_LOAD   = 3'd1;
  localparam logic [2:0] IT_STORE  = 3'd2;
  localparam logic [2:0] IT_BRANCH = 3'd3;
  localparam logic [2:0] IT_JUMP   = 3'd4;
  localparam logic [2:0] IT_OUTPUT = 3'd5;
  localparam logic [2:0] IT_NOP    = 3'd6;

  localparam logic [3:0] OP_LHI   = 4'd6;
  localparam logic [3:0] OP_JAL   = 4'd10;
  localparam logic [3:0] OP_RTYPE = 4'd15;
  localparam logic [5:0] FUNC_JRL = 6'd26;
  localparam logic [5:0] FUNC_HLT = 6'd29;

  localparam bit FAST = (FAST_PATH != 0);
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  state_t            state, state_next;
  logic [WAIT_W-1:0] wait_cnt, wait_inc;
  logic              fetch_req, load_req, store_req, addr_sel, timed_out;

  logic is_hlt, is_lhi, is_link, is_load, is_store, is_branch;
  logic is_jump, is_output, is_nop, writes_reg;

  // bcond is consumed by the datapath together with pc_write_cond.
  logic unused_bcond;
  assign unused_bcond = bcond;

  assign is_hlt     = (opcode == OP_RTYPE) && (func_code == FUNC_HLT);
  assign is_lhi     = (opcode == OP_LHI);
  assign is_link    = (opcode == OP_JAL) || ((opcode == OP_RTYPE) && (func_code == FUNC_JRL));
  assign is_load    = (inst_type == IT_LOAD) && !is_lhi;
  assign is_store   = (inst_type == IT_STORE);
  assign is_branch  = (inst_type == IT_BRANCH);
  assign is_jump    = (inst_type == IT_JUMP);
  assign is_output  = (inst_type == IT_OUTPUT);
  assign is_nop     = (inst_type == IT_NOP);
  assign writes_reg = (inst_type == IT_RTYPE) || (inst_type == IT_LOAD) || is_link;

  assign wait_inc = wait_cnt + 1'b1;

  always_comb begin
    state_next    = state;
    fetch_req     = 1'b0;
    load_req      = 1'b0;
    store_req     = 1'b0;
    addr_sel      = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    reg_write     = 1'b0;
    output_write  = 1'b0;
    halted        = 1'b0;
    timed_out     = 1'b0;
    case (state)
      S_IF: begin
        fetch_req = 1'b1;
        if (mem.mem_ready) begin
          // Held in reset the state is already IF; keep the IR untouched.
          ir_write   = reset_n;
          state_next = S_ID;
        end
      end
      S_ID: begin
        if (is_hlt) begin
          state_next = S_HALT;
        end else if (FAST && is_nop) begin
          pc_write   = 1'b1;
          state_next = S_IF;
        end else if (FAST && is_output) begin
          output_write = 1'b1;
          pc_write     = 1'b1;
          state_next   = S_IF;
        end else begin
          state_next = S_EX;
        end
      end
      S_EX: begin
        if (!FAST) begin
          output_write = is_output;
          state_next   = S_MEM;
        end else if (is_branch) begin
          pc_write_cond = 1'b1;
          state_next    = S_IF;
        end else if (is_jump && !is_link) begin
          pc_write   = 1'b1;
          state_next = S_IF;
        end else if (is_load || is_store) begin
          state_next = S_MEM;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        addr_sel  = 1'b1;
        load_req  = is_load;
        store_req = is_store;
        if (!(is_load || is_store)) begin
          state_next = S_WB;
        end else if (mem.mem_ready) begin
          if (is_store && FAST) begin
            pc_write   = 1'b1;
            state_next = S_IF;
          end else begin
            state_next = S_WB;
          end
        end
      end
      S_WB: begin
        reg_write = writes_reg;
        if (is_branch) pc_write_cond = 1'b1;
        else           pc_write      = 1'b1;
        state_next = S_IF;
      end
      S_HALT: halted = 1'b1;
      default: state_next = S_IF;
    endcase
    // A ready arriving in the limit cycle still completes the handshake.
    if ((MEM_TIMEOUT > 0) && (fetch_req || load_req || store_req) &&
        !mem.mem_ready && (wait_inc == WAIT_LIMIT)) begin
      state_next = S_HALT;
      timed_out  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IF;
      wait_cnt  <= '0;
      num_inst  <= '0;
      mem_error <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next != state)
        wait_cnt <= '0;
      else if ((fetch_req || load_req || store_req) && !mem.mem_ready)
        wait_cnt <= wait_inc;
      if ((state != S_IF) && (state_next == S_IF))
        num_inst <= num_inst + 1'b1;
      if (timed_out)
        mem_error <= 1'b1;
    end
  end

  assign mem.i_mem_read  = fetch_req;
  assign mem.d_mem_read  = load_req;
  assign mem.d_mem_write = store_req;
  assign mem.i_or_d      = addr_sel;
  assign stage           = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: a fast-path instance (CNT_W=4, MEM_TIMEOUT=4)
// and a five-stage instance (FAST_PATH=0, no timeout), each checked cycle by cycle against a path model.
module tb_multicycle_control;

  localparam int IT_R = 0, IT_LD = 1, IT_ST = 2, IT_BR = 3, IT_J = 4, IT_OUT = 5, IT_NOP = 6, IT_HLT = 7;
  localparam int K_ADD = 0, K_ADI = 1, K_ORI = 2, K_LHI = 3, K_LWD = 4, K_SWD = 5, K_BNE = 6, K_BEQ = 7;
  localparam int K_JMP = 8, K_JPR = 9, K_JAL = 10, K_JRL = 11, K_WWD = 12, K_NOP = 13, K_HLT = 14;
  localparam int C_ALU = 0, C_LHI = 1, C_LD = 2, C_ST = 3, C_BR = 4, C_JMP = 5, C_LINK = 6;
  localparam int C_OUT = 7, C_NOP = 8, C_HLT = 9;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_f = 1'b0, rst_s = 1'b0;

  logic [3:0] opcode = '0;
  logic [5:0] func_code = '0;
  logic [2:0] inst_type = '0;
  logic       mem_ready = 1'b0, bcond = 1'b0;
  logic       sel = 1'b0;

  multicycle_control_if bus_f ();
  multicycle_control_if bus_s ();
  assign bus_f.mem_ready = mem_ready;
  assign bus_s.mem_ready = mem_ready;

  logic irw_f, pcw_f, pcc_f, rw_f, ow_f, h_f, me_f, irw_s, pcw_s, pcc_s, rw_s, ow_s, h_s, me_s;
  logic [3:0]  num_f;
  logic [15:0] num_s;
  logic [2:0]  stage_f, stage_s;

  multicycle_control #(.CNT_W(4), .MEM_TIMEOUT(4), .FAST_PATH(1)) dut_f (
    .clk(clk), .reset_n(rst_f), .opcode(opcode), .func_code(func_code), .inst_type(inst_type),
    .bcond(bcond), .mem(bus_f), .ir_write(irw_f), .pc_write(pcw_f), .pc_write_cond(pcc_f),
    .reg_write(rw_f), .output_write(ow_f), .halted(h_f), .mem_error(me_f), .num_inst(num_f),
    .stage(stage_f));

  multicycle_control #(.CNT_W(16), .MEM_TIMEOUT(0), .FAST_PATH(0)) dut_s (
    .clk(clk), .reset_n(rst_s), .opcode(opcode), .func_code(func_code), .inst_type(inst_type),
    .bcond(bcond), .mem(bus_s), .ir_write(irw_s), .pc_write(pcw_s), .pc_write_cond(pcc_s),
    .reg_write(rw_s), .output_write(ow_s), .halted(h_s), .mem_error(me_s), .num_inst(num_s),
    .stage(stage_s));

  logic [15:0] vec_f, vec_s, cur_vec, cur_num;
  assign vec_f = {2'b00, stage_f, bus_f.i_mem_read, bus_f.d_mem_read, bus_f.d_mem_write, bus_f.i_or_d,
                  irw_f, pcw_f, pcc_f, rw_f, ow_f, h_f, me_f};
  assign vec_s = {2'b00, stage_s, bus_s.i_mem_read, bus_s.d_mem_read, bus_s.d_mem_write, bus_s.i_or_d,
                  irw_s, pcw_s, pcc_s, rw_s, ow_s, h_s, me_s};
  assign cur_vec = sel ? vec_s : vec_f;
  assign cur_num = sel ? num_s : {12'd0, num_f};

  // scoreboard state
  int          n_total = 0, n_bad = 0;
  int          model_cnt = 0;
  logic [15:0] exp_q[$];
  logic        rdy_q[$];
  int          done_at, dmr_cycles, regw_pulses;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk(input int st, input bit imr, input bit dmr, input bit dmw,
                                     input bit iod, input bit irw, input bit pcw, input bit pcc,
                                     input bit rw, input bit ow, input bit h, input bit me);
    logic [2:0] s3;
    s3 = 3'(st);
    return {2'b00, s3, imr, dmr, dmw, iod, irw, pcw, pcc, rw, ow, h, me};
  endfunction

  localparam logic [15:0] RESET_VEC = 16'h0400;  // stage IF, i_mem_read only

  function automatic int cls_of(input int k);
    case (k)
      K_ADD, K_ADI, K_ORI: return C_ALU;
      K_LHI:               return C_LHI;
      K_LWD:               return C_LD;
      K_SWD:               return C_ST;
      K_BNE, K_BEQ:        return C_BR;
      K_JMP, K_JPR:        return C_JMP;
      K_JAL, K_JRL:        return C_LINK;
      K_WWD:               return C_OUT;
      K_NOP:               return C_NOP;
      default:             return C_HLT;
    endcase
  endfunction

  // driver: present an instruction's IR fields (immediate bits randomized where they are not a func code)
  task automatic set_inst(input int k);
    int it, op, fn;
    fn = $urandom_range(0, 63);
    case (k)
      K_ADD: begin it = IT_R;   op = 15; fn = 0;  end
      K_ADI: begin it = IT_R;   op = 4;  end
      K_ORI: begin it = IT_R;   op = 5;  end
      K_LHI: begin it = IT_LD;  op = 6;  end
      K_LWD: begin it = IT_LD;  op = 7;  end
      K_SWD: begin it = IT_ST;  op = 8;  end
      K_BNE: begin it = IT_BR;  op = 0;  end
      K_BEQ: begin it = IT_BR;  op = 1;  end
      K_JMP: begin it = IT_J;   op = 9;  end
      K_JPR: begin it = IT_J;   op = 15; fn = 25; end
      K_JAL: begin it = IT_J;   op = 10; end
      K_JRL: begin it = IT_J;   op = 15; fn = 26; end
      K_WWD: begin it = IT_OUT; op = 15; fn = 28; end
      K_NOP: begin it = IT_NOP; op = 15; fn = 30; end
      default: begin it = IT_HLT; op = 15; fn = 29; end
    endcase
    inst_type = 3'(it);
    opcode    = 4'(op);
    func_code = 6'(fn);
  endtask

  // reference model: stage path per instruction class, PC strobe on the retiring cycle
  task automatic build_model(input int k, input bit fast, input int if_wait, input int mem_wait);
    int  path[$];
    int  cls, s, n;
    bit  req, memop, rdy_cyc, last, writes;
    cls = cls_of(k);
    writes = (cls == C_ALU) || (cls == C_LHI) || (cls == C_LD) || (cls == C_LINK);
    if (cls == C_HLT)                       path = '{0, 1};
    else if (!fast)                         path = '{0, 1, 2, 3, 4};
    else if (cls == C_NOP || cls == C_OUT)  path = '{0, 1};
    else if (cls == C_BR || cls == C_JMP)   path = '{0, 1, 2};
    else if (cls == C_ST)                   path = '{0, 1, 2, 3};
    else if (cls == C_LD)                   path = '{0, 1, 2, 3, 4};
    else                                    path = '{0, 1, 2, 4};
    for (int i = 0; i < path.size(); i++) begin
      s = path[i];
      memop = (s == 3) && (cls == C_LD || cls == C_ST);
      req = (s == 0) || memop;
      n = req ? 1 + ((s == 0) ? if_wait : mem_wait) : 1;
      for (int c = 0; c < n; c++) begin
        rdy_cyc = req && (c == n - 1);
        last = (i == path.size() - 1) && (c == n - 1) && (cls != C_HLT);
        rdy_q.push_back(req ? rdy_cyc : 1'($urandom_range(0, 1)));
        exp_q.push_back(mk(s, s == 0, s == 3 && cls == C_LD, s == 3 && cls == C_ST, s == 3,
                           s == 0 && rdy_cyc, last && cls != C_BR, last && cls == C_BR,
                           s == 4 && writes, cls == C_OUT && s == (fast ? 1 : 2), 1'b0, 1'b0));
      end
    end
    if (cls == C_HLT) begin
      rdy_q.push_back(1'($urandom_range(0, 1)));
      exp_q.push_back(mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0));
    end
  endtask

  // driver + monitor: starts and ends at posedge+1
  task automatic run_inst(input int k, input int if_wait, input int mem_wait);
    logic [15:0] e;
    int          cyc;
    logic [15:0] mask;
    mask = sel ? 16'hFFFF : 16'h000F;
    set_inst(k);
    build_model(k, !sel, if_wait, mem_wait);
    cyc = 0; done_at = 0; dmr_cycles = 0; regw_pulses = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      mem_ready = rdy_q.pop_front();
      bcond = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
      check("cycle", cur_vec, e);
      if (cur_vec[9]) dmr_cycles++;
      if (cur_vec[3]) regw_pulses++;
      if ((cur_vec[5] || cur_vec[4]) && done_at == 0) done_at = cyc;
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    if (cls_of(k) != C_HLT) begin
      model_cnt++;
      check("num_inst", cur_num, 16'(model_cnt) & mask);
    end
  endtask

  task automatic do_reset(input bit which);
    sel = which;
    rst_f = 1'b0;
    rst_s = 1'b0;
    mem_ready = 1'b1;
    set_inst($urandom_range(0, 14));
    @(negedge clk);
    check("reset_vec", cur_vec, RESET_VEC);
    check("reset_num", cur_num, 16'd0);
    mem_ready = 1'b0;
    @(posedge clk); #1;
    if (which) rst_s = 1'b1;
    else       rst_f = 1'b1;
    model_cnt = 0;
  endtask

  task automatic idle_cycle(input bit rdy);
    mem_ready = rdy;
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (2) @(posedge clk);
    #1;

    // fast instance: counter wrap with 17 NOPs
    do_reset(1'b0);
    for (int i = 0; i < 17; i++) run_inst(K_NOP, 0, 0);
    check("wrap_num", cur_num, 16'd1);

    // sample program, zero-wait memory
    do_reset(1'b0);
    run_inst(K_ADD, 0, 0);
    run_inst(K_LWD, 0, 0);
    run_inst(K_SWD, 0, 0);
    run_inst(K_BNE, 0, 0);
    run_inst(K_JAL, 0, 0);
    run_inst(K_HLT, 0, 0);
    check("prog_num", cur_num, 16'd5);
    check("prog_halted", {15'd0, cur_vec[1]}, 16'd1);

    // delayed load and ready exactly at the timeout limit
    do_reset(1'b0);
    run_inst(K_LWD, 0, 3);
    check("lwd_len", 16'(done_at), 16'd8);
    check("lwd_dmr", 16'(dmr_cycles), 16'd4);
    check("lwd_regw", 16'(regw_pulses), 16'd1);
    run_inst(K_LWD, 3, 3);
    run_inst(K_SWD, 3, 3);

    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 13);
      run_inst(k, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // reset in the middle of a store
    do_reset(1'b0);
    set_inst(K_SWD);
    idle_cycle(1'b1);
    idle_cycle(1'b0);
    idle_cycle(1'b1);
    mem_ready = 1'b0;
    @(negedge clk);
    check("swd_mem", cur_vec, mk(3, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    #2 rst_f = 1'b0;
    #1 check("abort_vec", cur_vec, RESET_VEC);
    check("abort_num", cur_num, 16'd0);
    @(posedge clk); #1;
    rst_f = 1'b1;
    @(negedge clk);
    check("restart_vec", cur_vec, RESET_VEC);
    check("restart_num", cur_num, 16'd0);
    @(posedge clk); #1;
    model_cnt = 0;
    run_inst(K_NOP, 0, 0);

    // fetch timeout
    do_reset(1'b0);
    run_inst(K_NOP, 0, 0);
    run_inst(K_WWD, 0, 0);
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("if_wait", cur_vec, RESET_VEC);
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    @(negedge clk);
    check("if_timeout", cur_vec, mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1));
    check("if_timeout_num", cur_num, 16'd2);
    @(posedge clk); #1;
    @(negedge clk);
    check("halt_stays", cur_vec, mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1));
    @(posedge clk); #1;

    // load timeout
    do_reset(1'b0);
    set_inst(K_LWD);
    idle_cycle(1'b1);
    idle_cycle(1'b0);
    idle_cycle(1'b0);
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mem_wait", cur_vec, mk(3, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("mem_timeout", cur_vec, mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1));
    check("mem_timeout_num", cur_num, 16'd0);
    @(posedge clk); #1;

    // five-stage instance
    do_reset(1'b1);
    run_inst(K_BEQ, 0, 0);
    check("beq_len", 16'(done_at), 16'd5);
    run_inst(K_NOP, 9, 0);
    check("no_timeout_len", 16'(done_at), 16'd14);
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 13);
      run_inst(k, $urandom_range(0, 6), $urandom_range(0, 6));
    end
    run_inst(K_HLT, 1, 0);
    check("slow_halted", {15'd0, cur_vec[1]}, 16'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
